adder_axi_master_ctrl: RTL and testbench

// - AXI4-Lite master sequencer for the memory-mapped adder slave.
// - Accepts one operand pair per request and runs the full transaction:

---
 rtl/adder_axi_master_ctrl_if.sv | 33 +++
 rtl/adder_axi_master_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_adder_axi_master_ctrl.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_axi_master_ctrl_if.sv
// AXI4-Lite bus bundle between the adder sequencer (master) and the adder slave.
interface adder_axi_master_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/adder_axi_master_ctrl.sv
// AXI4-Lite master that writes A/B to the adder slave and reads back sum/overflow.
// Optional per-phase watchdog enabled by defining ADDER_CTRL_TIMEOUT_EN.
module adder_axi_master_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  m1_axi_aclk,
    input  logic                  m1_axi_aresetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_WIDTH-1:0] req_a,
    input  logic [DATA_WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_sum,
    output logic                  rsp_ovf,
    output logic                  rsp_err,
    adder_axi_master_ctrl_if.master m1_axi
);
    localparam logic [ADDR_WIDTH-1:0] ADDR_A   = ADDR_WIDTH'(8'h00);
    localparam logic [ADDR_WIDTH-1:0] ADDR_B   = ADDR_WIDTH'(8'h04);
    localparam logic [ADDR_WIDTH-1:0] ADDR_SUM = ADDR_WIDTH'(8'h08);
    localparam logic [ADDR_WIDTH-1:0] ADDR_OVF = ADDR_WIDTH'(8'h0C);

    typedef enum logic [2:0] {IDLE, WR_A, WR_B, RD_SUM, RD_OVF, RESP} state_t;

    state_t                state_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [ADDR_WIDTH-1:0] araddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic                  aw_done_q, w_done_q;
    logic [DATA_WIDTH-1:0] sum_q;
    logic                  ovf_q, err_q, rsp_valid_q;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    assign aw_hs = awvalid_q & m1_axi.awready;
    assign w_hs  = wvalid_q  & m1_axi.wready;
    assign b_hs  = bready_q  & m1_axi.bvalid;
    assign ar_hs = arvalid_q & m1_axi.arready;
    assign r_hs  = rready_q  & m1_axi.rvalid;

`ifdef ADDER_CTRL_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q;
`endif

    always_ff @(posedge m1_axi_aclk or negedge m1_axi_aresetn) begin
        if (!m1_axi_aresetn) begin
            state_q     <= IDLE;
            b_q         <= '0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            sum_q       <= '0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
`ifdef ADDER_CTRL_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        b_q       <= req_b;
                        wdata_q   <= req_a;
                        awaddr_q  <= ADDR_A;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        err_q     <= 1'b0;
                        state_q   <= WR_A;
                    end
                end
                WR_A, WR_B: begin
                    if (bready_q) begin
                        if (m1_axi.bvalid) begin
                            bready_q  <= 1'b0;
                            aw_done_q <= 1'b0;
                            w_done_q  <= 1'b0;
                            if (m1_axi.bresp[1]) err_q <= 1'b1;
                            if (state_q == WR_A) begin
                                awaddr_q  <= ADDR_B;
                                wdata_q   <= b_q;
                                awvalid_q <= 1'b1;
                                wvalid_q  <= 1'b1;
                                state_q   <= WR_B;
                            end else begin
                                araddr_q  <= ADDR_SUM;
                                arvalid_q <= 1'b1;
                                state_q   <= RD_SUM;
                            end
                        end
                    end else begin
                        // AW and W complete independently; bready follows the later one.
                        if (aw_hs) begin
                            awvalid_q <= 1'b0;
                            aw_done_q <= 1'b1;
                        end
                        if (w_hs) begin
                            wvalid_q <= 1'b0;
                            w_done_q <= 1'b1;
                        end
                        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) bready_q <= 1'b1;
                    end
                end
                RD_SUM, RD_OVF: begin
                    if (arvalid_q) begin
                        if (m1_axi.arready) begin
                            arvalid_q <= 1'b0;
                            rready_q  <= 1'b1;
                        end
                    end else if (r_hs) begin
                        rready_q <= 1'b0;
                        if (m1_axi.rresp[1]) err_q <= 1'b1;
                        if (state_q == RD_SUM) begin
                            sum_q     <= m1_axi.rdata;
                            araddr_q  <= ADDR_OVF;
                            arvalid_q <= 1'b1;
                            state_q   <= RD_OVF;
                        end else begin
                            ovf_q       <= m1_axi.rdata[0];
                            rsp_valid_q <= 1'b1;
                            state_q     <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
`ifdef ADDER_CTRL_TIMEOUT_EN
            // Any handshake starts a new phase; a stalled phase aborts to RESP with an error.
            if (state_q == IDLE || state_q == RESP || aw_hs || w_hs || b_hs || ar_hs || r_hs) begin
                tmo_q <= '0;
            end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                awvalid_q   <= 1'b0;
                wvalid_q    <= 1'b0;
                bready_q    <= 1'b0;
                arvalid_q   <= 1'b0;
                rready_q    <= 1'b0;
                err_q       <= 1'b1;
                sum_q       <= '0;
                ovf_q       <= 1'b0;
                rsp_valid_q <= 1'b1;
                state_q     <= RESP;
                tmo_q       <= '0;
            end else begin
                tmo_q <= tmo_q + 1'b1;
            end
`endif
        end
    end

`ifndef ADDER_CTRL_TIMEOUT_EN
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES ^ b_hs ^ ar_hs;
`endif
    logic unused_resp;
    assign unused_resp = m1_axi.bresp[0] ^ m1_axi.rresp[0];

    assign req_ready      = (state_q == IDLE);
    assign rsp_valid      = rsp_valid_q;
    assign rsp_sum        = sum_q;
    assign rsp_ovf        = ovf_q;
    assign rsp_err        = err_q;
    assign m1_axi.awaddr  = awaddr_q;
    assign m1_axi.awvalid = awvalid_q;
    assign m1_axi.wdata   = wdata_q;
    assign m1_axi.wstrb   = '1;
    assign m1_axi.wvalid  = wvalid_q;
    assign m1_axi.bready  = bready_q;
    assign m1_axi.araddr  = araddr_q;
    assign m1_axi.arvalid = arvalid_q;
    assign m1_axi.rready  = rready_q;
endmodule

// File: tb/tb_adder_axi_master_ctrl.sv
// Directed bench for adder_axi_master_ctrl with a small AXI4-Lite adder slave model.
module tb_adder_axi_master_ctrl;
    localparam int DW = 32;
    localparam int AW = 8;
`ifdef ADDER_CTRL_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 255;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [DW-1:0] req_a = '0;
    logic [DW-1:0] req_b = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_sum;
    logic          rsp_ovf;
    logic          rsp_err;

    always #5 clk = ~clk;

    adder_axi_master_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) m1_axi ();

    adder_axi_master_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
        .m1_axi_aclk   (clk),
        .m1_axi_aresetn(rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_sum       (rsp_sum),
        .rsp_ovf       (rsp_ovf),
        .rsp_err       (rsp_err),
        .m1_axi        (m1_axi)
    );

    // Slave model: configurable W/AW stalls, AR blocking and an error address for B.
    int          aw_wait = 0;
    int          w_wait = 0;
    logic        ar_block = 1'b0;
    logic [7:0]  err_waddr = 8'hFF;
    int          aw_cnt, w_cnt;
    logic        aw_seen, w_seen;
    logic [7:0]  aw_addr_l;
    logic [31:0] w_data_l;
    logic [31:0] regs [2];
    int          wr_cnt [4];
    int          rd_cnt [4];
    logic [31:0] wr_data [4];
    logic [7:0]  a_eff;
    logic [31:0] d_eff;
    logic [32:0] sum33;

    assign m1_axi.awready = m1_axi.awvalid && (aw_cnt >= aw_wait);
    assign m1_axi.wready  = m1_axi.wvalid && (w_cnt >= w_wait);
    assign m1_axi.arready = m1_axi.arvalid && !ar_block;
    assign a_eff = aw_seen ? aw_addr_l : m1_axi.awaddr;
    assign d_eff = w_seen ? w_data_l : m1_axi.wdata;
    assign sum33 = {1'b0, regs[0]} + {1'b0, regs[1]};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_cnt        <= 0;
            w_cnt         <= 0;
            aw_seen       <= 1'b0;
            w_seen        <= 1'b0;
            aw_addr_l     <= '0;
            w_data_l      <= '0;
            regs[0]       <= '0;
            regs[1]       <= '0;
            m1_axi.bvalid <= 1'b0;
            m1_axi.bresp  <= 2'b00;
            m1_axi.rvalid <= 1'b0;
            m1_axi.rdata  <= '0;
            m1_axi.rresp  <= 2'b00;
            for (int i = 0; i < 4; i++) begin
                wr_cnt[i]  <= 0;
                rd_cnt[i]  <= 0;
                wr_data[i] <= '0;
            end
        end else begin
            aw_cnt <= (m1_axi.awvalid && !m1_axi.awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (m1_axi.wvalid && !m1_axi.wready) ? w_cnt + 1 : 0;
            if (m1_axi.awvalid && m1_axi.awready) begin
                aw_seen   <= 1'b1;
                aw_addr_l <= m1_axi.awaddr;
            end
            if (m1_axi.wvalid && m1_axi.wready) begin
                w_seen   <= 1'b1;
                w_data_l <= m1_axi.wdata;
            end
            if (m1_axi.bvalid && m1_axi.bready) m1_axi.bvalid <= 1'b0;
            if ((aw_seen || (m1_axi.awvalid && m1_axi.awready)) &&
                (w_seen || (m1_axi.wvalid && m1_axi.wready)) && !m1_axi.bvalid) begin
                m1_axi.bvalid      <= 1'b1;
                m1_axi.bresp       <= (a_eff == err_waddr) ? 2'b10 : 2'b00;
                wr_cnt[a_eff[3:2]] <= wr_cnt[a_eff[3:2]] + 1;
                wr_data[a_eff[3:2]] <= d_eff;
                if (a_eff[3] == 1'b0) regs[a_eff[2]] <= d_eff;
                aw_seen <= 1'b0;
                w_seen  <= 1'b0;
            end
            if (m1_axi.rvalid && m1_axi.rready) m1_axi.rvalid <= 1'b0;
            if (m1_axi.arvalid && m1_axi.arready) begin
                m1_axi.rvalid <= 1'b1;
                m1_axi.rresp  <= 2'b00;
                rd_cnt[m1_axi.araddr[3:2]] <= rd_cnt[m1_axi.araddr[3:2]] + 1;
                m1_axi.rdata  <= (m1_axi.araddr == 8'h08) ? sum33[31:0] : {31'b0, sum33[32]};
            end
        end
    end

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic start_req(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        chk("req_ready_idle", {63'b0, req_ready}, 64'd1);
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input int lat0, output int lat);
        lat = lat0;
        for (int i = 0; i < 300 && !rsp_valid; i++) begin
            @(posedge clk);
            #1 lat++;
        end
        if (!rsp_valid) chk({tag, "_rsp_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic accept_rsp(input string tag);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        chk({tag, "_rsp_drop"}, {63'b0, rsp_valid}, 64'd0);
        chk({tag, "_b2b_ready"}, {63'b0, req_ready}, 64'd1);
    endtask

    task automatic run_txn(input string tag, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] sum, output logic ovf, output logic err, output int lat);
        start_req(a, b);
        wait_rsp(tag, 1, lat);
        sum = rsp_sum;
        ovf = rsp_ovf;
        err = rsp_err;
        $display("txn %s a=0x%08h b=0x%08h sum=0x%08h ovf=%0b err=%0b lat=%0d", tag, a, b, sum, ovf, err, lat);
        accept_rsp(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=running exp=finished");
        $fatal(1, "watchdog");
    end

    logic [31:0] s;
    logic        o, e;
    int          lat;
    int          w0, w1, r2, r3;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", {63'b0, req_ready}, 64'd1);
        chk("rst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
        chk("rst_valids", {60'b0, m1_axi.awvalid, m1_axi.wvalid, m1_axi.arvalid, rsp_err}, 64'd0);
        chk("rst_readies", {62'b0, m1_axi.bready, m1_axi.rready}, 64'd0);
        chk("rst_wstrb", {60'b0, m1_axi.wstrb}, 64'hF);
        chk("rst_addr_data", {m1_axi.wdata, 8'b0, 8'b0, m1_axi.awaddr, m1_axi.araddr}, 64'd0);
        chk("rst_sum", {32'b0, rsp_sum}, 64'd0);
        @(negedge clk) rst_n = 1'b1;

        // Zero-wait slave, 5 + 7
        w0 = wr_cnt[0]; w1 = wr_cnt[1]; r2 = rd_cnt[2]; r3 = rd_cnt[3];
        run_txn("basic", 32'd5, 32'd7, s, o, e, lat);
        chk("basic_sum", {32'b0, s}, 64'd12);
        chk("basic_ovf_err", {62'b0, o, e}, 64'd0);
        chk("basic_lat", 64'(lat), 64'd9);
        chk("basic_wdata_a", {32'b0, wr_data[0]}, 64'd5);
        chk("basic_wdata_b", {32'b0, wr_data[1]}, 64'd7);
        chk("basic_wr_counts", {32'(wr_cnt[0] - w0), 32'(wr_cnt[1] - w1)}, {32'd1, 32'd1});
        chk("basic_rd_counts", {32'(rd_cnt[2] - r2), 32'(rd_cnt[3] - r3)}, {32'd1, 32'd1});

        // Back-to-back overflow case, result held while rsp_ready stays low
        start_req(32'hFFFF_FFFF, 32'd1);
        wait_rsp("ovf", 1, lat);
        chk("ovf_lat", 64'(lat), 64'd9);
        repeat (3) @(posedge clk);
        #1;
        $display("txn ovf a=0xffffffff b=0x00000001 sum=0x%08h ovf=%0b err=%0b lat=%0d", rsp_sum, rsp_ovf, rsp_err, lat);
        chk("ovf_hold_valid", {63'b0, rsp_valid}, 64'd1);
        chk("ovf_sum", {32'b0, rsp_sum}, 64'd0);
        chk("ovf_flags", {62'b0, rsp_ovf, rsp_err}, 64'd2);
        chk("ovf_req_ready_resp", {63'b0, req_ready}, 64'd0);
        accept_rsp("ovf");

        // W channel stalls 3 cycles behind AW
        w_wait = 3;
        w0 = wr_cnt[0]; w1 = wr_cnt[1];
        start_req(32'd3, 32'd4);
        @(posedge clk);
        #1;
        chk("wstall_aw_dropped", {63'b0, m1_axi.awvalid}, 64'd0);
        chk("wstall_w_held", {63'b0, m1_axi.wvalid}, 64'd1);
        chk("wstall_no_bready", {63'b0, m1_axi.bready}, 64'd0);
        wait_rsp("wstall", 2, lat);
        $display("txn wstall a=0x00000003 b=0x00000004 sum=0x%08h ovf=%0b err=%0b lat=%0d", rsp_sum, rsp_ovf, rsp_err, lat);
        chk("wstall_sum", {32'b0, rsp_sum}, 64'd7);
        chk("wstall_lat", 64'(lat), 64'd15);
        chk("wstall_wr_counts", {32'(wr_cnt[0] - w0), 32'(wr_cnt[1] - w1)}, {32'd1, 32'd1});
        accept_rsp("wstall");
        w_wait = 0;

        // SLVERR on the B write: reads still issued, error sticky
        err_waddr = 8'h04;
        r2 = rd_cnt[2]; r3 = rd_cnt[3];
        run_txn("berr", 32'd1, 32'd2, s, o, e, lat);
        chk("berr_err", {63'b0, e}, 64'd1);
        chk("berr_sum", {32'b0, s}, 64'd3);
        chk("berr_rd_counts", {32'(rd_cnt[2] - r2), 32'(rd_cnt[3] - r3)}, {32'd1, 32'd1});
        err_waddr = 8'hFF;
        run_txn("errclr", 32'd2, 32'd2, s, o, e, lat);
        chk("errclr_err", {63'b0, e}, 64'd0);
        chk("errclr_sum", {32'b0, s}, 64'd4);

        // AR never accepted: wait forever, or time out when the watchdog is built in
        ar_block = 1'b1;
        start_req(32'd9, 32'd9);
        for (int i = 0; i < 20 && !m1_axi.arvalid; i++) begin
            @(posedge clk);
            #1;
        end
        chk("arblk_arvalid", {63'b0, m1_axi.arvalid}, 64'd1);
`ifdef ADDER_CTRL_TIMEOUT_EN
        wait_rsp("tmo", 1, lat);
        $display("txn tmo a=0x00000009 b=0x00000009 sum=0x%08h ovf=%0b err=%0b", rsp_sum, rsp_ovf, rsp_err);
        chk("tmo_arvalid", {63'b0, m1_axi.arvalid}, 64'd0);
        chk("tmo_rsp", {61'b0, rsp_valid, rsp_err, rsp_ovf}, 64'd6);
        chk("tmo_sum", {32'b0, rsp_sum}, 64'd0);
`else
        repeat (40) @(posedge clk);
        #1;
        $display("txn arblk a=0x00000009 b=0x00000009 arvalid=%0b rsp_valid=%0b", m1_axi.arvalid, rsp_valid);
        chk("arblk_held", {63'b0, m1_axi.arvalid}, 64'd1);
        chk("arblk_no_rsp", {63'b0, rsp_valid}, 64'd0);
`endif
        // Asynchronous reset while stuck in the sum read
        rst_n = 1'b0;
        #1;
        chk("midrst_ar_r", {62'b0, m1_axi.arvalid, m1_axi.rready}, 64'd0);
        chk("midrst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
        ar_block = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_req_ready", {63'b0, req_ready}, 64'd1);
        chk("midrst_no_rsp", {63'b0, rsp_valid}, 64'd0);

        run_txn("post", 32'h1234_5678, 32'h1111_1111, s, o, e, lat);
        chk("post_sum", {32'b0, s}, 64'h2345_6789);
        chk("post_flags", {62'b0, o, e}, 64'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
